// File: rtl/char_blitter_if.sv
// Bus between the text sequencer / glyph ROM / frame-buffer write port and
// the character blitter. The blitter is the slave; whoever drives the
// character requests and returns ROM data is the master.
interface char_blitter_if #(
  parameter int CHAR_WIDTH = 20
);
  logic                  start;
  logic [7:0]            char_code;
  logic [18:0]           base_addr;
  logic [12:0]           glyph_addr;
  logic [CHAR_WIDTH-1:0] glyph_row;
  logic [18:0]           fb_addr;
  logic [7:0]            fb_data;
  logic                  fb_we;
  logic                  busy;
  logic                  done;

  modport master (
    output start, char_code, base_addr, glyph_row,
    input  glyph_addr, fb_addr, fb_data, fb_we, busy, done
  );

  modport slave (
    input  start, char_code, base_addr, glyph_row,
    output glyph_addr, fb_addr, fb_data, fb_we, busy, done
  );
endinterface

// File: rtl/char_blitter.sv
// Character blitter: renders one glyph into the 640-wide pixel frame buffer.
// Per glyph row: one cycle to present the ROM address, one cycle to latch
// the ROM data, then CHAR_WIDTH cycles writing one pixel each.
module char_blitter #(
  parameter int         CHAR_WIDTH   = 20,
  parameter int         CHAR_HEIGHT  = 30,
  parameter int         SCREEN_WIDTH = 640,
  parameter logic [7:0] FG_COLOR     = 8'hFF,
  parameter logic [7:0] BG_COLOR     = 8'h00
) (
  input  logic           clock,
  input  logic           reset,
  char_blitter_if.slave  bus
);

  localparam int COL_W = $clog2(CHAR_WIDTH);
  localparam int ROW_W = $clog2(CHAR_HEIGHT);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] DRAW  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]            state_reg;
  logic [COL_W-1:0]      col_reg;
  logic [ROW_W-1:0]      row_reg;
  logic [CHAR_WIDTH-1:0] shift_reg;
  logic [18:0]           row_base_reg;
  logic [12:0]           glyph_addr_reg;
  logic [18:0]           fb_addr_reg;
  logic [7:0]            fb_data_reg;

  // State machine plus all datapath registers. fb_addr/fb_data are loaded one
  // cycle ahead so that they are stable for the whole DRAW cycle they belong
  // to, and simply hold once drawing stops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      col_reg        <= '0;
      row_reg        <= '0;
      shift_reg      <= '0;
      row_base_reg   <= '0;
      glyph_addr_reg <= '0;
      fb_addr_reg    <= '0;
      fb_data_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            // Only multiply in the design: seeds the ROM address once per glyph.
            glyph_addr_reg <= 13'(bus.char_code) * 13'(CHAR_HEIGHT);
            row_base_reg   <= bus.base_addr;
            row_reg        <= '0;
            col_reg        <= '0;
            state_reg      <= FETCH;
          end
        end

        FETCH: begin
          // glyph_addr is already on the ROM port; its data appears next cycle.
          state_reg <= LOAD;
        end

        LOAD: begin
          // Column 0 is the ROM word MSB; emit it now, keep the rest shifted.
          shift_reg   <= {bus.glyph_row[CHAR_WIDTH-2:0], 1'b0};
          fb_addr_reg <= row_base_reg;
          fb_data_reg <= bus.glyph_row[CHAR_WIDTH-1] ? FG_COLOR : BG_COLOR;
          col_reg     <= '0;
          state_reg   <= DRAW;
        end

        DRAW: begin
          if (col_reg == COL_W'(CHAR_WIDTH - 1)) begin
            col_reg <= '0;
            if (row_reg < ROW_W'(CHAR_HEIGHT - 1)) begin
              row_reg        <= row_reg + 1'b1;
              glyph_addr_reg <= glyph_addr_reg + 13'd1;
              row_base_reg   <= row_base_reg + 19'(SCREEN_WIDTH);
              state_reg      <= FETCH;
            end else begin
              state_reg <= DONE;
            end
          end else begin
            col_reg     <= col_reg + 1'b1;
            fb_addr_reg <= fb_addr_reg + 19'd1;
            fb_data_reg <= shift_reg[CHAR_WIDTH-1] ? FG_COLOR : BG_COLOR;
            shift_reg   <= {shift_reg[CHAR_WIDTH-2:0], 1'b0};
          end
        end

        DONE: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Status strobes decode straight from the state register so that an
  // asynchronous reset clears them in the same cycle.
  assign bus.fb_we      = (state_reg == DRAW);
  assign bus.busy       = (state_reg == FETCH) || (state_reg == LOAD) || (state_reg == DRAW);
  assign bus.done       = (state_reg == DONE);
  assign bus.glyph_addr = glyph_addr_reg;
  assign bus.fb_addr    = fb_addr_reg;
  assign bus.fb_data    = fb_data_reg;

endmodule

// File: tb/tb_char_blitter.sv
// Directed bench for char_blitter: glyph ROM model, write monitor with an
// independent address/pixel model, and a linear sequence of directed steps.
module tb_char_blitter;

  logic clock;
  logic reset;

  char_blitter_if #(.CHAR_WIDTH(20)) bus ();

  char_blitter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Stimulus-side expectations used by the monitor
  int exp_base = 0;
  int pattern  = 0;   // 0: all-ones glyph, 1: rows alternate AAAAA / 55555

  // Absolute cycle counter
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Registered glyph ROM model: even glyph rows AAAAA, odd rows 55555
  // (char_code*30 is always even, so glyph_addr parity is the row parity).
  always @(posedge clock) begin
    if (pattern == 0)
      bus.glyph_row <= 20'hFFFFF;
    else
      bus.glyph_row <= bus.glyph_addr[0] ? 20'h55555 : 20'hAAAAA;
  end

  function automatic logic [7:0] exp_pix(input int pat, input int k);
    int r;
    int c;
    r = k / 20;
    c = k % 20;
    if (pat == 0) return 8'hFF;
    return (((r + c) % 2) == 0) ? 8'hFF : 8'h00;
  endfunction

  // Per-operation statistics gathered by the monitor
  int t0 = 0;
  int t0_prev = 0;
  int wr_cnt = 0;
  int tot_wr = 0;
  int ff_cnt = 0;
  int addr_err = 0;
  int data_err = 0;
  int first_wr = -1;
  int done_cnt = 0;
  int done_cyc = -1;
  int busy_cnt = 0;
  int ga_min = 8191;
  int ga_max = 0;
  int last_addr = -1;
  int wa0 = -1;
  int wa19 = -1;
  int wa20 = -1;
  logic [7:0] wd0 = 8'h5A;
  logic [7:0] wd1 = 8'h5A;
  logic [7:0] wd20 = 8'h5A;

  // Monitor on the falling edge, away from the DUT's active edge
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.start && !bus.busy && !bus.done) begin
        t0_prev  <= t0;
        t0       <= cyc;
        wr_cnt   <= 0;
        ff_cnt   <= 0;
        addr_err <= 0;
        data_err <= 0;
        first_wr <= -1;
        done_cnt <= 0;
        done_cyc <= -1;
        busy_cnt <= 0;
        ga_min   <= 8191;
        ga_max   <= 0;
      end else begin
        if (bus.fb_we) begin
          if (32'(bus.fb_addr) != ((exp_base + (wr_cnt / 20) * 640 + (wr_cnt % 20)) % 524288))
            addr_err <= addr_err + 1;
          if (bus.fb_data !== exp_pix(pattern, wr_cnt))
            data_err <= data_err + 1;
          if (bus.fb_data == 8'hFF) ff_cnt <= ff_cnt + 1;
          if (wr_cnt == 0) begin
            first_wr <= cyc - t0;
            wa0      <= int'(bus.fb_addr);
            wd0      <= bus.fb_data;
          end
          if (wr_cnt == 1)  wd1 <= bus.fb_data;
          if (wr_cnt == 19) wa19 <= int'(bus.fb_addr);
          if (wr_cnt == 20) begin
            wa20 <= int'(bus.fb_addr);
            wd20 <= bus.fb_data;
          end
          last_addr <= int'(bus.fb_addr);
          wr_cnt    <= wr_cnt + 1;
          tot_wr    <= tot_wr + 1;
        end
        if (bus.busy) begin
          busy_cnt <= busy_cnt + 1;
          if (int'(bus.glyph_addr) < ga_min) ga_min <= int'(bus.glyph_addr);
          if (int'(bus.glyph_addr) > ga_max) ga_max <= int'(bus.glyph_addr);
        end
        if (bus.done) begin
          done_cnt <= done_cnt + 1;
          done_cyc <= cyc - t0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents one request for exactly one accepting edge, then scrambles the
  // inputs to show they are not needed after capture.
  task automatic start_char(input logic [7:0] code, input int base, input int pat);
    exp_base      = base;
    pattern       = pat;
    bus.char_code = code;
    bus.base_addr = 19'(base);
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.char_code = 8'($urandom);
    bus.base_addr = 19'($urandom);
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (done_cnt == 0 && n < max_cycles) begin
      tick();
      n++;
    end
    chk(tag, 32'(done_cnt != 0), 32'd1);
  endtask

  task automatic report(input string name);
    $display("%s: base %0d writes %0d first@%0d done@%0d last_addr %0d glyph %0d..%0d",
             name, exp_base, wr_cnt, first_wr, done_cyc, last_addr, ga_min, ga_max);
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.char_code = 8'h00;
    bus.base_addr = 19'd0;

    // 1. Reset state and quiet idle
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_fb_we", 32'(bus.fb_we), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_fb_addr", 32'(bus.fb_addr), 32'd0);
    chk("rst_fb_data", 32'(bus.fb_data), 32'd0);
    chk("rst_glyph_addr", 32'(bus.glyph_addr), 32'd0);
    repeat (50) tick();
    chk("idle_no_writes", 32'(tot_wr), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // 2. Solid glyph in the middle of the screen
    start_char(8'h41, 153600, 0);
    wait_done("t2_done_seen", 800);
    repeat (3) tick();
    report("t2");
    chk("t2_writes", 32'(wr_cnt), 32'd600);
    chk("t2_all_ff", 32'(ff_cnt), 32'd600);
    chk("t2_first_cycle", 32'(first_wr), 32'd3);
    chk("t2_first_addr", 32'(wa0), 32'd153600);
    chk("t2_last_addr", 32'(last_addr), 32'd172179);
    chk("t2_addr_model", 32'(addr_err), 32'd0);
    chk("t2_glyph_min", 32'(ga_min), 32'd1950);
    chk("t2_glyph_max", 32'(ga_max), 32'd1979);
    chk("t2_done_count", 32'(done_cnt), 32'd1);
    chk("t2_done_cycle", 32'(done_cyc), 32'd661);
    chk("t2_busy_cycles", 32'(busy_cnt), 32'd660);

    // 3. Checkerboard glyph: bit order and row stride
    start_char(8'h02, 1000, 1);
    wait_done("t3_done_seen", 800);
    report("t3");
    chk("t3_writes", 32'(wr_cnt), 32'd600);
    chk("t3_r0c0", 32'(wd0), 32'hFF);
    chk("t3_r0c1", 32'(wd1), 32'h00);
    chk("t3_r1c0", 32'(wd20), 32'h00);
    chk("t3_row_span", 32'(wa19 - wa0), 32'd19);
    chk("t3_row_stride", 32'(wa20 - wa0), 32'd640);
    chk("t3_pixel_model", 32'(data_err), 32'd0);
    chk("t3_addr_model", 32'(addr_err), 32'd0);

    // 4. Last cell on screen, highest glyph code
    start_char(8'hFF, 288620, 0);
    wait_done("t4_done_seen", 800);
    report("t4");
    chk("t4_glyph_min", 32'(ga_min), 32'd7650);
    chk("t4_glyph_max", 32'(ga_max), 32'd7679);
    chk("t4_last_addr", 32'(last_addr), 32'd307199);
    chk("t4_addr_model", 32'(addr_err), 32'd0);

    // 5. Starts during busy and during DONE are ignored; earliest restart
    start_char(8'h10, 5000, 1);          // now in cycle 1
    repeat (9) tick();                   // cycle 10
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;                    // cycle 11
    repeat (650) tick();                 // cycle 661 (DONE)
    chk("t5_done_at_661", 32'(bus.done), 32'd1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;                    // cycle 662
    report("t5a");
    chk("t5_writes", 32'(wr_cnt), 32'd600);
    chk("t5_done_count", 32'(done_cnt), 32'd1);
    chk("t5_done_cycle", 32'(done_cyc), 32'd661);
    chk("t5_pixel_model", 32'(data_err), 32'd0);
    chk("t5_idle_after", 32'(bus.busy), 32'd0);
    start_char(8'h11, 6000, 0);          // accepted in cycle 662
    chk("t5_restart_gap", 32'(t0 - t0_prev), 32'd662);
    wait_done("t5b_done_seen", 800);
    report("t5b");
    chk("t5b_first_cycle", 32'(first_wr), 32'd3);
    chk("t5b_writes", 32'(wr_cnt), 32'd600);

    // 6. Asynchronous reset mid-draw, then a fresh character at address 0
    start_char(8'h20, 20000, 0);         // now in cycle 1
    repeat (99) tick();                  // cycle 100, inside a DRAW run
    chk("t6_drawing_before", 32'(bus.fb_we), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_async_fb_we", 32'(bus.fb_we), 32'd0);
    chk("t6_async_busy", 32'(bus.busy), 32'd0);
    chk("t6_async_done", 32'(bus.done), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    start_char(8'h00, 0, 0);
    wait_done("t6_done_seen", 800);
    report("t6");
    chk("t6_writes", 32'(wr_cnt), 32'd600);
    chk("t6_first_addr", 32'(wa0), 32'd0);
    chk("t6_last_addr", 32'(last_addr), 32'd18579);
    chk("t6_addr_model", 32'(addr_err), 32'd0);
    chk("t6_done_count", 32'(done_cnt), 32'd1);

    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/char_blitter.md
Name: char_blitter

Overview:
- Downstream consumer of the character-index-to-pixel-address mapper.
- Takes one character's frame-buffer base address and its glyph code, then renders the glyph into the 640-wide pixel frame buffer.
- Fetches glyph rows from a registered glyph ROM and writes one pixel per cycle.
- Sits between the text-buffer sequencer/mapper and the VGA frame-buffer RAM write port.

Parameters:
- CHAR_WIDTH, 20, glyph width in pixels (= bits per glyph ROM row)
- CHAR_HEIGHT, 30, glyph height in rows
- SCREEN_WIDTH, 640, frame-buffer pixels per line
- FG_COLOR, 8'hFF, pixel value written for glyph bit 1
- BG_COLOR, 8'h00, pixel value written for glyph bit 0

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request to draw one character; sampled only in IDLE
- char_code  in  8  glyph index to draw
- base_addr  in  19  top-left pixel address from the mapper
- glyph_addr  out  13  glyph ROM address = char_code*CHAR_HEIGHT + row
- glyph_row  in  CHAR_WIDTH  ROM data; valid one cycle after glyph_addr
- fb_addr  out  19  frame-buffer write address
- fb_data  out  8  frame-buffer write pixel
- fb_we  out  1  frame-buffer write enable
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse when the character is complete

Behaviour:
- Clock and reset: one clock (clock); reset is asynchronous and active-high.
- Reset values: state = IDLE; all outputs 0 (fb_we, busy, done, fb_addr, fb_data, glyph_addr); row and column counters 0.
- States: IDLE -> FETCH -> LOAD -> DRAW -> (FETCH | DONE) -> IDLE.
- IDLE:
  - If start = 1, capture char_code and base_addr, set busy = 1, go to FETCH.
  - The upstream mapper has one-cycle registered latency, so the sequencer presents count one cycle before asserting start.
- FETCH (1 cycle): glyph_addr registered to char_code*CHAR_HEIGHT + row.
  - Computed by an incrementing register (+1 per row, seeded with char_code*CHAR_HEIGHT at start); no per-row multiply.
- LOAD (1 cycle): glyph_row valid this cycle; latch it into a CHAR_WIDTH-bit shift register.
- DRAW (CHAR_WIDTH cycles, col 0..CHAR_WIDTH-1):
  - fb_we = 1.
  - fb_addr = row_base + col, where row_base = base_addr + row*SCREEN_WIDTH is maintained incrementally (+SCREEN_WIDTH per row).
  - fb_data = FG_COLOR if the current bit is 1, else BG_COLOR.
  - Bit order: glyph_row MSB is column 0 (leftmost).
  - After col = CHAR_WIDTH-1: if row < CHAR_HEIGHT-1, increment row and go to FETCH; else go to DONE.
- DONE (1 cycle): done = 1, busy = 0, fb_we = 0, then IDLE.
- fb_we is 0 in every state other than DRAW; fb_addr and fb_data hold their last values when fb_we = 0.
- Latency: start accepted at cycle 0 -> first write at cycle 3 -> last write at cycle 660 -> done at cycle 661. A new start is accepted at cycle 662 at the earliest.
- Throughput: 22 cycles per row, 660 pixel-path cycles per character.
- start while busy, or during the DONE cycle, is ignored; there is no queueing.
- Arithmetic: address sums are unsigned mod 2^19, with no saturation or clipping. With the standard text region, the maximum address is 307199, which fits.
- Input stability: char_code and base_addr may change freely after capture.
- Reset mid-operation: fb_we, busy and done drop to 0 immediately (asynchronously); the next start after reset behaves as a fresh operation.

Test Plan:
1. Assert reset, then release -> fb_we = busy = done = 0, fb_addr = 0, glyph_addr = 0; no writes for 50 idle cycles.
2. base_addr = 153600, char_code = 8'h41, ROM returns all ones -> exactly 600 writes, all fb_data = 8'hFF.
   - First write at cycle 3 to address 153600; last write to 172179.
   - glyph_addr steps 1950..1979; done pulses once at cycle 661.
3. Glyph rows alternate 20'hAAAAA / 20'h55555 -> row 0 col 0 = FG, col 1 = BG; row 1 col 0 = BG; addresses contiguous within each row with stride 640 between rows.
4. Last cell: base_addr = 288620, char_code = 8'hFF -> glyph_addr ends at 7679; last write address 307199; no wrap.
5. Pulse start again at cycles 10 and 661 during an operation -> ignored; exactly 600 writes and one done pulse. Start at cycle 662 -> second character begins, first write at cycle 665.
6. Assert reset at cycle 100 mid-DRAW -> fb_we and busy are 0 in the same cycle. After release, a start with base_addr = 0 produces 600 writes to addresses 0..18579 (row 29 spans 18560..18579).
